// File: rtl/keypad_pkg.sv
// Purpose: shared FSM state encoding and width helper for the keypad scanner.
// Latency: none, declarations only.
// Backpressure: none.
// Contents: state_e (scanner FSM states), kp_width() (bits needed to index n items).
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int kp_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Purpose: key event bundle from the scanner to its consumer.
// Latency: none, wires only.
// Backpressure: none; key_valid is a one-cycle pulse the consumer must catch.
// Signals: key_code (row*COLS+col), key_valid (accept pulse), key_held (key down level).
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    import keypad_pkg::*;

    localparam int KW = kp_width(ROWS * COLS);

    logic [KW-1:0] key_code;
    logic          key_valid;
    logic          key_held;

    modport master (output key_code, key_valid, key_held);
    modport slave  (input  key_code, key_valid, key_held);

endinterface

// File: rtl/onehot_enc.sv
// Purpose: one-hot to binary index encoder with a single-bit-set flag.
// Latency: combinational.
// Backpressure: none.
// Ports: in_vec (candidate one-hot), index (highest set bit), valid (exactly one bit set).
module onehot_enc #(
    parameter int WIDTH = 4,
    parameter int IW    = keypad_pkg::kp_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [IW-1:0]    index,
    output logic             valid
);

    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in_vec[i]) begin
                index = IW'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
    assign valid = (in_vec != '0) && ((in_vec & (in_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: row-scanned matrix keypad decoder with debounce and single-key lockout.
// Latency: press to key_valid within (ROWS+DEB_CNT+1)*SCAN_DIV+3 cycles for a stable key.
// Backpressure: none; key_valid pulses once per accepted press, key_held shows key down.
// Ports: clk, rst_n (async active-low), col_in (raw columns), row_sel (one-hot row drive),
//        keys (master side: key_code, key_valid, key_held).
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COLS-1:0]     col_in,
    output logic [ROWS-1:0]     row_sel,
    keypad_scanner_if.master    keys
);
    import keypad_pkg::*;

    localparam int KW = kp_width(ROWS * COLS);
    localparam int RW = kp_width(ROWS);
    localparam int CW = kp_width(COLS);
    localparam int DW = kp_width(SCAN_DIV);
    localparam int NW = kp_width(DEB_CNT);

    localparam logic [1:0] S_SCAN     = ST_SCAN;
    localparam logic [1:0] S_DEBOUNCE = ST_DEBOUNCE;
    localparam logic [1:0] S_HELD     = ST_HELD;
    localparam logic [1:0] S_RELEASE  = ST_RELEASE;

    logic [COLS-1:0] col_m;
    logic [COLS-1:0] col_s;
    logic [DW-1:0]   div_cnt;
    logic [1:0]      state;
    logic [RW-1:0]   row_idx;
    logic [RW-1:0]   row_nxt;
    logic [COLS-1:0] col_cap;
    logic [NW-1:0]   deb_cnt;
    logic [CW-1:0]   enc_idx;
    logic            enc_vld;
    logic            sample;
    logic            col_zero;
    logic            col_same;
    logic            deb_done;
    logic            advance;

    onehot_enc #(.WIDTH(COLS), .IW(CW)) u_enc (
        .in_vec (col_s),
        .index  (enc_idx),
        .valid  (enc_vld)
    );

    // Sampling on the last slot cycle gives the row drive and synchroniser time to settle.
    assign sample   = (div_cnt == DW'(SCAN_DIV - 1));
    assign col_zero = (col_s == '0);
    assign col_same = (col_s == col_cap);
    assign deb_done = (deb_cnt == NW'(DEB_CNT - 1));
    assign row_nxt  = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);

    // Rows only move while scanning or when leaving a key; they stay frozen on the key row otherwise.
    assign advance = sample &&
                     (((state == S_SCAN)     && !enc_vld) ||
                      ((state == S_DEBOUNCE) && !col_same) ||
                      ((state == S_RELEASE)  && col_zero && deb_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= '0;
            col_s <= '0;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= sample ? '0 : div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx <= '0;
            row_sel <= ROWS'(1);
        end else if (advance) begin
            row_idx <= row_nxt;
            row_sel <= ROWS'(1) << row_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_SCAN;
            col_cap        <= '0;
            deb_cnt        <= '0;
            keys.key_code  <= '0;
            keys.key_valid <= 1'b0;
            keys.key_held  <= 1'b0;
        end else begin
            keys.key_valid <= 1'b0;
            if (sample) begin
                case (state)
                    S_SCAN: begin
                        if (enc_vld) begin
                            col_cap <= col_s;
                            deb_cnt <= '0;
                            state   <= S_DEBOUNCE;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (!col_same) begin
                            state <= S_SCAN;
                        end else if (deb_done) begin
                            // Row is still frozen and col_s equals the capture, so both index live.
                            keys.key_code  <= KW'(row_idx) * KW'(COLS) + KW'(enc_idx);
                            keys.key_valid <= 1'b1;
                            keys.key_held  <= 1'b1;
                            state          <= S_HELD;
                        end else begin
                            deb_cnt <= deb_cnt + NW'(1);
                        end
                    end
                    S_HELD: begin
                        // Any other key on this row keeps us here: single-key lockout.
                        if (col_zero) begin
                            deb_cnt <= '0;
                            state   <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (!col_zero) begin
                            state <= S_HELD;
                        end else if (deb_done) begin
                            keys.key_held <= 1'b0;
                            state         <= S_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + NW'(1);
                        end
                    end
                    default: state <= S_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose: directed scoreboard bench for keypad_scanner (4x4, SCAN_DIV=8, DEB_CNT=3).
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEB_CNT  = 3;
    localparam int LAT_MAX  = (ROWS + DEB_CNT + 1) * SCAN_DIV + 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col_in;
    logic [3:0]  row_sel;
    logic [15:0] keys;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .col_in  (col_in),
        .row_sel (row_sel),
        .keys    (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key connects its row drive to its column.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel[r]) col_in = col_in | keys[r*4 +: 4];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_held(input logic v, input int budget, input string name, output int n);
        n = 0;
        while (kif.key_held !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, kif.key_held, v);
    endtask

    task automatic wait_row(input logic [3:0] v, input int budget, input string name);
        int n = 0;
        while (row_sel !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, row_sel, v);
    endtask

    task automatic wait_row_change(input int budget, input string name, input logic [3:0] exp);
        logic [3:0] prev = row_sel;
        int n = 0;
        while (row_sel === prev && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, row_sel, exp);
    endtask

    // Monitor: every key_valid pulse must match the next expected key code.
    initial begin
        int exp;
        forever begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_key_valid actual key_code=%0d required no pulse", kif.key_code);
                end else begin
                    exp = exp_q.pop_front();
                    check("key_code_on_valid", kif.key_code, exp);
                    check("held_with_valid", kif.key_held, 1);
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        check("rst_row_sel", row_sel, 4'b0001);
        check("rst_key_code", kif.key_code, 0);
        check("rst_key_valid", kif.key_valid, 0);
        check("rst_key_held", kif.key_held, 0);
        rst_n = 1'b1;

        // Stable press, row 2 col 1.
        exp_q.push_back(9);
        keys[9] = 1'b1;
        wait_held(1'b1, LAT_MAX, "stable_press_held", n);
        repeat (80) @(negedge clk);
        check("stable_still_held", kif.key_held, 1);
        check("stable_row_frozen", row_sel, 4'b0100);
        keys[9] = 1'b0;
        wait_held(1'b0, 60, "stable_release", n);
        check("code_kept_after_release", kif.key_code, 9);

        // Bouncing contact on row 1 col 2, then settled.
        exp_q.push_back(6);
        keys[6] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            repeat (5) @(negedge clk);
            keys[6] = ~keys[6];
        end
        keys[6] = 1'b1;
        wait_held(1'b1, LAT_MAX, "bounce_held", n);
        keys[6] = 1'b0;
        wait_held(1'b0, 60, "bounce_release", n);

        // Two keys on one row: ignored, scanning continues.
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        wait_row(4'b0001, 40, "dual_row0");
        for (int i = 0; i < 4; i++) wait_row_change(12, "dual_row_cycle", seq[i]);
        check("dual_no_held", kif.key_held, 0);
        keys[0] = 1'b0;
        keys[3] = 1'b0;
        repeat (10) @(negedge clk);

        // Lockout: second key on the same row while the first is held.
        exp_q.push_back(5);
        keys[5] = 1'b1;
        wait_held(1'b1, LAT_MAX, "lock_first_held", n);
        keys[7] = 1'b1;
        repeat (50) @(negedge clk);
        keys[7] = 1'b0;
        repeat (50) @(negedge clk);
        check("lock_still_held", kif.key_held, 1);
        check("lock_code", kif.key_code, 5);
        keys[5] = 1'b0;
        wait_held(1'b0, 60, "lock_release", n);
        checks++;
        if (n < 27 || n > 34) begin
            failures++;
            $display("FAIL release_latency actual=%0d required=27..34", n);
        end

        // Reset asserted while debouncing row 2 col 1.
        wait_row(4'b0010, 40, "rstdeb_row1");
        keys[9] = 1'b1;
        wait_row(4'b0100, 12, "rstdeb_row2");
        repeat (12) @(negedge clk);
        check("rstdeb_row_frozen", row_sel, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("rstdeb_row_sel", row_sel, 4'b0001);
        check("rstdeb_key_code", kif.key_code, 0);
        check("rstdeb_key_held", kif.key_held, 0);
        check("rstdeb_key_valid", kif.key_valid, 0);
        keys[9] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("rstdeb_no_held", kif.key_held, 0);

        // Corner key row 3 col 3 with wrap before and after.
        wait_row(4'b1000, 40, "corner_row3");
        wait_row_change(12, "corner_wrap_before", 4'b0001);
        exp_q.push_back(15);
        keys[15] = 1'b1;
        wait_held(1'b1, LAT_MAX, "corner_held", n);
        check("corner_row_frozen", row_sel, 4'b1000);
        keys[15] = 1'b0;
        wait_held(1'b0, 60, "corner_release", n);
        check("corner_wrap_after", row_sel, 4'b0001);
        check("corner_code_kept", kif.key_code, 15);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of driven keypad rows (2..16).
REQ-002 SHALL have parameter COLS, default 4, number of sensed keypad columns (2..16).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clk cycles each row is driven per sample slot (>=4).
REQ-004 SHALL have parameter DEB_CNT, default 8, consecutive agreeing samples required for press or release (>=2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port col_in  input  COLS  raw column levels, active-high, asynchronous to clk.
REQ-008 SHALL have port row_sel  output  ROWS  one-hot row drive enable, active-high.
REQ-009 SHALL have port key_code  output  clog2(ROWS*COLS)  row*COLS+col of last accepted key.
REQ-010 SHALL have port key_valid  output  1  single-cycle pulse on accepted press.
REQ-011 SHALL have port key_held  output  1  high while accepted key not yet released.

Function
REQ-012 SHALL pass col_in through a 2-flop synchroniser before any use; col_s denotes the synchronised value.
REQ-013 SHALL sample col_s once per slot, on the last cycle of each SCAN_DIV-cycle slot (settling margin).
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, HELD, RELEASE.
REQ-015 SCAN: row_sel SHALL advance one-hot by one position per slot, wrapping from row ROWS-1 to row 0.
REQ-016 SCAN: a sample with exactly one col_s bit set SHALL capture row/col, clear debounce counter, enter DEBOUNCE, and freeze row_sel.
REQ-017 SCAN: a sample with zero or more than one col_s bit set SHALL be ignored (no capture, row advances).
REQ-018 DEBOUNCE: each sample equal to the captured one-hot column SHALL increment the counter; on reaching DEB_CNT the FSM SHALL enter HELD.
REQ-019 DEBOUNCE: any differing sample SHALL return to SCAN, row_sel advancing to the next row at the next slot boundary, key outputs unchanged.
REQ-020 On DEBOUNCE->HELD, key_code SHALL update and key_valid SHALL pulse high for exactly one cycle, same cycle as key_held rises.
REQ-021 HELD: row_sel SHALL stay frozen; a sample with col_s all-zero SHALL clear counter and enter RELEASE; other samples keep HELD.
REQ-022 RELEASE: each all-zero sample SHALL increment counter; at DEB_CNT key_held SHALL fall and FSM SHALL enter SCAN at the next row; any nonzero sample SHALL return to HELD with no new key_valid.
REQ-023 Single-key lockout: no second key_valid SHALL occur until the held key completes RELEASE, regardless of other keys pressed.
REQ-024 key_code SHALL hold its value until the next accepted press.
REQ-025 Press-to-key_valid latency SHALL be at most (ROWS+DEB_CNT+1)*SCAN_DIV+3 cycles for a stable single key.

Reset
REQ-026 On rst_n low, asynchronously: FSM=SCAN, row_sel=1 (row 0), key_code=0, key_valid=0, key_held=0, counters and synchroniser flops=0.
REQ-027 Reset asserted mid-DEBOUNCE, HELD or RELEASE SHALL discard the key with no key_valid pulse; after release of rst_n scanning restarts at row 0.

Structure
REQ-028 Shared package keypad_pkg SHALL hold the FSM state enum and a clog2-based width function for key_code and counters.
REQ-029 The column one-hot-to-binary conversion SHALL be a sub-module onehot_enc (parameter WIDTH; outputs index and single-hot valid flag, valid=0 for zero or multiple bits set).

Verification
REQ-030 Stable press row 2 col 1 (ROWS=COLS=4, SCAN_DIV=8, DEB_CNT=3) -> one key_valid pulse, key_code=9, key_held=1 until release completes.
REQ-031 Bounce: col toggles every 5 cycles for 60 cycles then settles -> exactly one key_valid, key_code correct.
REQ-032 Two columns on same row pressed together -> no key_valid, row_sel keeps cycling 1,2,4,8,1.
REQ-033 Key held, second key pressed then released, first released -> one key_valid only; key_held falls after DEB_CNT all-zero samples.
REQ-034 rst_n asserted during DEBOUNCE -> outputs 0 immediately, row_sel=0001, no key_valid after reset release with keys released.
REQ-035 Press row 3 col 3 with ROWS=COLS=4 -> key_code=15, row_sel wraps 8->1 correctly before and after.
